// File: rtl/alu_seq_responder_pkg.sv
// Shared opcodes and state encodings for the sequential ALU responder.
// Also holds a small opcode-classification helper.
package alu_seq_responder_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_shift(input logic [3:0] fn);
    return (fn == ALU_SRL) || (fn == ALU_SRA) || (fn == ALU_SLL);
  endfunction
endpackage

// File: rtl/alu_seq_responder_shift_stage.sv
// One-bit combinational shift step: dir=1 shifts left, otherwise right.
// A right shift refills with the MSB when arith is set.
module alu_seq_shift_stage #(
  parameter int N = 32
) (
  input  logic [N-1:0] value,
  input  logic         dir,
  input  logic         arith,
  output logic [N-1:0] result
);
  assign result = dir ? {value[N-2:0], 1'b0}
                      : {arith & value[N-1], value[N-1:1]};
endmodule

// File: rtl/alu_seq_responder.sv
// Sequential ALU responder: single-cycle arithmetic/logic, iterative 1-bit shifter,
// valid/ready on both request and result sides, one operation in flight.
module alu_seq_responder
  import alu_seq_responder_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alufn,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] C,
  output logic         ZeroFlag,
  output logic         CarryFlag,
  output logic         OverflowFlag,
  output logic         SignFlag
);
  logic [1:0]     state;
  logic [N-1:0]   work, step;
  logic [SHW-1:0] cnt;
  logic           dir, arith;

  logic [SHW-1:0] shamt;
  logic           is_add, add_c, add_v, slt, sltu;
  logic [N-1:0]   b_op, res;
  logic [N:0]     sum;
  logic           accept, start_shift;

  assign shamt = B[SHW-1:0];

  // Only ADD adds; every other opcode (including illegal ones) runs the adder as A-B.
  always_comb begin
    is_add = (alufn == ALU_ADD);
    b_op   = is_add ? B : ~B;
    sum    = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, ~is_add};
    add_c  = sum[N];
    add_v  = (A[N-1] == b_op[N-1]) && (sum[N-1] != A[N-1]);
    slt    = sum[N-1] ^ add_v;
    sltu   = ~add_c;
  end

  always_comb begin
    res = '0;
    case (alufn)
      ALU_ADD, ALU_SUB:          res = sum[N-1:0];
      ALU_PASS:                  res = B;
      ALU_OR:                    res = A | B;
      ALU_AND:                   res = A & B;
      ALU_XOR:                   res = A ^ B;
      ALU_SRL, ALU_SRA, ALU_SLL: res = A;  // only reached with shamt == 0
      ALU_SLT:                   res = {{(N-1){1'b0}}, slt};
      ALU_SLTU:                  res = {{(N-1){1'b0}}, sltu};
      default:                   res = '0;
    endcase
  end

  assign accept      = (state == ST_IDLE) && in_valid;
  assign start_shift = accept && is_shift(alufn) && (shamt != '0);
  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);

  alu_seq_shift_stage #(.N(N)) u_step (
    .value  (work),
    .dir    (dir),
    .arith  (arith),
    .result (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      work         <= '0;
      cnt          <= '0;
      dir          <= 1'b0;
      arith        <= 1'b0;
      C            <= '0;
      ZeroFlag     <= 1'b0;
      CarryFlag    <= 1'b0;
      OverflowFlag <= 1'b0;
      SignFlag     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          // Adder flags come from the operands at accept, even for shifts.
          CarryFlag    <= add_c;
          OverflowFlag <= add_v;
          if (start_shift) begin
            work  <= A;
            cnt   <= shamt;
            dir   <= (alufn == ALU_SLL);
            arith <= (alufn == ALU_SRA);
            state <= ST_SHIFT;
          end else begin
            C        <= res;
            ZeroFlag <= (res == '0);
            SignFlag <= res[N-1];
            state    <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          work <= step;
          cnt  <= cnt - 1'b1;
          if (cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
            C        <= step;
            ZeroFlag <= (step == '0);
            SignFlag <= step[N-1];
            state    <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_responder.sv
// Directed scoreboard bench for alu_seq_responder: expected results are queued at
// request time from an independent model and checked when the result appears.
module tb_alu_seq_responder;
  localparam int N = 32;
  localparam int SHW = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   alufn = 4'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         in_ready, out_valid;
  logic [N-1:0] C;
  logic         ZeroFlag, CarryFlag, OverflowFlag, SignFlag;

  alu_seq_responder #(.N(N), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alufn(alufn), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .ZeroFlag(ZeroFlag), .CarryFlag(CarryFlag),
    .OverflowFlag(OverflowFlag), .SignFlag(SignFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        z, cy, ov, s;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    int sh;
    sh = int'(b[4:0]);
    if (fn == 4'b0000) begin
      s    = {1'b0, a} + {1'b0, b};
      e.ov = (a[31] == b[31]) && (s[31] != a[31]);
    end else begin
      s    = {1'b0, a} + {1'b0, ~b} + 33'd1;
      e.ov = (a[31] != b[31]) && (s[31] != a[31]);
    end
    e.cy = s[32];
    case (fn)
      4'b0000, 4'b0001: e.c = s[31:0];
      4'b0011: e.c = b;
      4'b0100: e.c = a | b;
      4'b0101: e.c = a & b;
      4'b0111: e.c = a ^ b;
      4'b1000: e.c = a >> sh;
      4'b1001: e.c = $signed(a) >>> sh;
      4'b1010: e.c = a << sh;
      4'b1101: e.c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: e.c = (a < b) ? 32'd1 : 32'd0;
      default: e.c = 32'd0;
    endcase
    e.z   = (e.c == 32'd0);
    e.s   = e.c[31];
    e.lat = ((fn == 4'b1000 || fn == 4'b1001 || fn == 4'b1010) && sh != 0) ? 1 + sh : 1;
    return e;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    exp_t e;
    int lat;
    wait_ready(tag);
    sb.push_back(model(fn, a, b));
    alufn = fn; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    // Scrambled inputs with in_valid high while busy must be ignored.
    A = ~a; B = ~b; alufn = 4'b0000;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    in_valid = 1'b0;
    e = sb.pop_front();
    chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
    chk({tag, ".C"}, 64'(C), 64'(e.c));
    chk({tag, ".flags_zcvs"}, 64'({ZeroFlag, CarryFlag, OverflowFlag, SignFlag}),
        64'({e.z, e.cy, e.ov, e.s}));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".stall_hold"}, {29'd0, out_valid, in_ready, ZeroFlag, C},
          {29'd0, 1'b1, 1'b0, e.z, e.c});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".after_handshake"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    int seen;
    @(negedge clk);
    chk("reset_state", {28'd0, in_ready, out_valid, ZeroFlag, CarryFlag, OverflowFlag, SignFlag, C},
        {28'd0, 1'b1, 1'b0, 4'b0000, 32'd0});
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sra_neg16_by1", 4'b1001, 32'hFFFF_FFF0, 32'd1, 0);
    run_op("sub_5_5",       4'b0001, 32'd5, 32'd5, 0);
    run_op("add_ovf",       4'b0000, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sll_1_by31",    4'b1010, 32'd1, 32'd31, 5);
    run_op("slt_m1_1",      4'b1101, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu_m1_1",     4'b1111, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("or",            4'b0100, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run_op("and",           4'b0101, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    run_op("xor",           4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 1);
    run_op("pass_b",        4'b0011, 32'h1234_5678, 32'h8000_0000, 0);
    run_op("srl_msb_by4",   4'b1000, 32'h8000_0001, 32'd4, 0);
    run_op("sra_msb_by31",  4'b1001, 32'h8000_0000, 32'd31, 0);
    run_op("sra_shamt0",    4'b1001, 32'h8000_0000, 32'h0000_0020, 0);
    run_op("sub_borrow",    4'b0001, 32'd3, 32'd7, 0);
    run_op("illegal_0010",  4'b0010, 32'd9, 32'd9, 0);
    run_op("illegal_1100",  4'b1100, 32'h8000_0000, 32'd1, 0);

    // Reset in the middle of a long shift: nothing may emerge afterwards.
    wait_ready("srl_reset");
    sb.push_back(model(4'b1000, 32'hDEAD_BEEF, 32'd20));
    alufn = 4'b1000; A = 32'hDEAD_BEEF; B = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_reset_state", {28'd0, in_ready, out_valid, ZeroFlag, CarryFlag, OverflowFlag, SignFlag, C},
        {28'd0, 1'b1, 1'b0, 4'b0000, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    out_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("no_stale_result", 64'(seen), 64'd0);
    run_op("add_2_3_after_reset", 4'b0000, 32'd2, 32'd3, 0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
